shift_sub_divider: RTL
======================

Name: shift_sub_divider

Overview:
- Sequential unsigned restoring divider (shift-and-subtract), one quotient bit per clock.
- Inverse of the shift-and-add multiplier in the datapath's arithmetic unit; shares its operand width and single-clock style.
- Computes quotient and remainder for the integer divide path.
- Uses a start/busy/done handshake, so the issuing control FSM knows when results are valid.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a divide; sampled only in IDLE or DONE state
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while in RUN state
- done  output  1  one-cycle pulse, results valid
- div_by_zero  output  1  set with done when the captured divisor was 0; held until next accepted start
- quotient  output  WIDTH  result quotient; held until next accepted start
- remainder  output  WIDTH  result remainder; held until next accepted start

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (`rst`).
- Reset values: on a `rst` edge, state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; internal regs and counter cleared.
- `rst` overrides `start`. Reset mid-RUN aborts the operation: no done pulse, outputs cleared.

States: IDLE, RUN, DONE.
- IDLE, start=1: capture dividend/divisor.
  - divisor==0: go to DONE. quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise: go to RUN. q_reg=dividend, r_reg=0, cnt=WIDTH-1, div_by_zero=0.
- RUN, each edge:
  - t = {r_reg, q_reg[WIDTH-1]}, which is WIDTH+1 bits wide so the compare cannot overflow.
  - q_reg shifts left by one.
  - If t >= {1'b0, divisor}: r_reg = t - divisor (low WIDTH bits) and q_reg[0]=1.
  - Else: r_reg = t[WIDTH-1:0] and q_reg[0]=0.
  - If cnt==0: go to DONE and load quotient/remainder from the post-step values. Else decrement cnt.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operation with no idle cycle.
  - Otherwise go to IDLE.
- start in RUN is ignored; the captured operands are unaffected by input changes after capture.

Latency and outputs:
- Let start be accepted at edge N.
- Nonzero divisor: busy=1 after edges N..N+WIDTH-1; done=1 in the cycle after edge N+WIDTH (WIDTH+1 cycles from start).
- Zero divisor: done=1 in the cycle after edge N.
- done and busy are registered and are never high simultaneously.
- quotient/remainder change only when entering DONE (or on reset).
- Result invariant: dividend == quotient*divisor + remainder, with remainder < divisor (nonzero divisor).
- Edge case: dividend < divisor gives quotient=0, remainder=dividend. No special-casing; falls out of the iteration.
- Edge case: dividend=0 gives 0/0 remainder, full WIDTH-cycle latency (no early termination).

Decomposition:
- Shared arithmetic package holds:
  - the state enumeration (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant, shared with the multiplier.
- Optional combinational sub-module `div_step`: inputs r_reg, q_reg msb, divisor; outputs next r_reg and quotient bit.
- Top level keeps the FSM, counter and registers.

Test Plan:
- 100/7 → done exactly 33 cycles after start edge; quotient=14, remainder=2, div_by_zero=0; busy high for 32 cycles.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0; then 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0.
- 5/0 → done in the cycle after the start edge; div_by_zero=1, quotient=0xFFFFFFFF, remainder=5; next accepted 9/3 clears div_by_zero with quotient=3, remainder=0.
- 3/10 → quotient=0, remainder=3. Re-pulse start=1 with 50/6 mid-RUN → ignored, first result unchanged.
- start with 1000/33 held high on the done cycle of the previous op → second op accepted with no idle cycle; quotient=30, remainder=10 after another 33 cycles.
- rst=1 at cycle 10 of 200/9 → next cycle all outputs 0, state IDLE, no done pulse. A new start then completes normally with quotient=22, remainder=2.

Source files
------------

// File: rtl/shift_sub_divider_pkg.sv
// Shared arithmetic definitions for the shift-and-add multiplier and the
// shift-and-subtract divider.
package shift_sub_divider_pkg;

  localparam int ARITH_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/shift_sub_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  // t is one bit wider than the remainder so the compare cannot overflow
  always_comb begin
    t     = {r_in, q_msb};
    diff  = t - {1'b0, divisor};
    q_bit = (t >= {1'b0, divisor});
    r_out = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake for the issuing control FSM.
//
// state | meaning
// IDLE  | waiting for start; results from the last op held
// RUN   | iterating, cnt counts down the remaining quotient bits
// DONE  | results valid for one cycle; start accepted back-to-back
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  div_state_e       state, next_state;
  logic [WIDTH-1:0] q_reg, r_reg, dvsr_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_reg),
    .q_msb   (q_reg[WIDTH-1]),
    .divisor (dvsr_reg),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start)              next_state = (divisor == '0) ? DONE : RUN;
        else if (state == DONE) next_state = IDLE;
      end
      RUN:     if (cnt == '0) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      r_reg       <= '0;
      dvsr_reg    <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q_reg       <= dividend;
        r_reg       <= '0;
        dvsr_reg    <= divisor;
        cnt         <= CNT_LOAD;
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      q_reg <= {q_reg[WIDTH-2:0], q_bit};
      r_reg <= r_next;
      // the last step writes the results straight from the step outputs
      if (cnt == '0) begin
        quotient  <= {q_reg[WIDTH-2:0], q_bit};
        remainder <= r_next;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
